// File: rtl/controlador_acesso_memoria.sv
// controlador_acesso_memoria
// Load/store access controller between the MEM stage and a word-addressed data
// RAM. The RAM has a registered 1-cycle read and an independent write port.
// Byte and halfword stores are done as read-modify-write of the whole word.
// Loads return the selected lane, sign- or zero-extended, with a one-cycle
// done pulse.
//
// Optional feature: define MEM_CTRL_ALIGN_CHECK_EN to detect and reject
// misaligned requests. When it is undefined, misaligned is always 0, the low
// address bits a half or word access cannot use are ignored, and size=11
// behaves as a word access.
module controlador_acesso_memoria #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic                  wr,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [ADDR_WIDTH+1:0] byte_addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  misaligned,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_FIM} state_t;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01,
                            SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_t;

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  state_t                  state_q;
  logic                    wr_q;
  size_t                   size_q;
  logic                    sign_q;
  logic [1:0]              lane_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   mem_data_q;
  logic                    mem_we_q;
  logic                    done_q;
  logic                    misaligned_q;

  size_t                   size_d;
  logic [1:0]              lane_d;
  logic                    align_bad;
  logic                    req_misaligned;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [DATA_WIDTH-1:0]   load_d;
  logic [DATA_WIDTH-1:0]   merge_d;

  // Normalise the incoming request: effective size, lane and alignment error.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    size_d    = SZ_BYTE;
    lane_d    = byte_addr[1:0];
    align_bad = 1'b0;
    case (size)
      2'b00: begin
        size_d = SZ_BYTE;
      end
      2'b01: begin
        size_d    = SZ_HALF;
        lane_d    = {byte_addr[1], 1'b0};
        align_bad = byte_addr[0];
      end
      default: begin
        // Reserved size is an error when checking, otherwise a plain word.
        size_d    = SZ_WORD;
        lane_d    = 2'b00;
        align_bad = (byte_addr[1:0] != 2'b00) || (size == 2'b11);
      end
    endcase
    req_misaligned = ALIGN_CHECK && align_bad;
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    byte_sel = mem_q[{lane_q, 3'b000} +: 8];
    half_sel = mem_q[{lane_q[1], 4'b0000} +: 16];
    load_d   = mem_q;
    merge_d  = wdata_q;
    case (size_q)
      SZ_BYTE: begin
        load_d  = {{24{sign_q & byte_sel[7]}}, byte_sel};
        merge_d = mem_q;
        merge_d[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_HALF: begin
        load_d  = {{16{sign_q & half_sel[15]}}, half_sel};
        merge_d = mem_q;
        merge_d[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: begin
        load_d  = mem_q;
        merge_d = wdata_q;
      end
    endcase
  end

  // Control FSM with registered outputs; reset aborts any transfer in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: every register, datapath included, is reset so outputs show a
      // defined value straight out of reset; there is no storage array here.
      state_q      <= S_IDLE;
      wr_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      sign_q       <= 1'b0;
      lane_q       <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      mem_data_q   <= '0;
      mem_we_q     <= 1'b0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      mem_we_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            wr_q    <= wr;
            size_q  <= size_d;
            sign_q  <= sign_ext;
            lane_q  <= lane_d;
            addr_q  <= byte_addr[ADDR_WIDTH+1:2];
            wdata_q <= wdata;
            if (req_misaligned) begin
              state_q      <= S_FIM;
              done_q       <= 1'b1;
              misaligned_q <= 1'b1;
            end else if (wr && (size_d == SZ_WORD)) begin
              state_q    <= S_WR;
              mem_we_q   <= 1'b1;
              mem_data_q <= wdata;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        S_RD: begin
          // RAM samples the read address on the edge leaving this state.
          state_q <= S_CAP;
        end
        S_CAP: begin
          if (wr_q) begin
            mem_data_q <= merge_d;
            mem_we_q   <= 1'b1;
            state_q    <= S_WR;
          end else begin
            rdata_q <= load_d;
            done_q  <= 1'b1;
            state_q <= S_FIM;
          end
        end
        S_WR: begin
          done_q  <= 1'b1;
          state_q <= S_FIM;
        end
        S_FIM: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready          = (state_q == S_IDLE);
  assign done           = done_q;
  assign rdata          = rdata_q;
  assign misaligned     = misaligned_q;
  assign mem_read_addr  = addr_q;
  assign mem_write_addr = addr_q;
  assign mem_data       = mem_data_q;
  assign mem_we         = mem_we_q;

endmodule

// File: tb/tb_controlador_acesso_memoria.sv
// Testbench for controlador_acesso_memoria: behavioural RAM with registered
// read, a byte-level reference model of memory and load results, directed
// scenarios followed by randomized accesses.
module tb_controlador_acesso_memoria;
  localparam int AW = 13;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req;
  logic          wr;
  logic [1:0]    size;
  logic          sign_ext;
  logic [AW+1:0] byte_addr;
  logic [31:0]   wdata;
  logic          ready;
  logic          done;
  logic [31:0]   rdata;
  logic          misaligned;
  logic [AW-1:0] mem_read_addr;
  logic [AW-1:0] mem_write_addr;
  logic [31:0]   mem_data;
  logic          mem_we;
  logic [31:0]   mem_q;

  logic [31:0]   ram [0:(1<<AW)-1];

  int            checks = 0;
  int            errors = 0;
  logic [31:0]   model_mem [16];
  logic [31:0]   model_rdata;

  int            we_count = 0;
  int            we_run = 0;
  int            we_long = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [31:0]   last_wr_data = '0;

  controlador_acesso_memoria #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req            (req),
    .wr             (wr),
    .size           (size),
    .sign_ext       (sign_ext),
    .byte_addr      (byte_addr),
    .wdata          (wdata),
    .ready          (ready),
    .done           (done),
    .rdata          (rdata),
    .misaligned     (misaligned),
    .mem_read_addr  (mem_read_addr),
    .mem_write_addr (mem_write_addr),
    .mem_data       (mem_data),
    .mem_we         (mem_we),
    .mem_q          (mem_q)
  );

  always #5 clock = ~clock;

  // Data RAM: registered read, independent write port.
  always @(posedge clock) begin
    mem_q <= ram[mem_read_addr];
    if (mem_we) ram[mem_write_addr] <= mem_data;
  end

  // Write-port monitor: counts write cycles, flags pulses longer than 1 cycle.
  always @(negedge clock) begin
    if (mem_we) begin
      we_count     <= we_count + 1;
      we_run       <= we_run + 1;
      last_wr_addr <= mem_write_addr;
      last_wr_data <= mem_data;
      if (we_run >= 1) we_long <= we_long + 1;
    end else begin
      we_run <= 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete request: model prediction, drive, wait for done, compare.
  task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                        input logic sx, input int addr, input logic [31:0] wd,
                        output logic [31:0] got);
    int     nb, off, idx, lat, n, we0;
    bit     mis;
    longint mask, word, val;
    nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    idx = addr / 4;
    off = addr % 4;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
    mis = (sz == 2'b11) || ((addr % nb) != 0);
`else
    mis = 1'b0;
`endif
    off  = off - (off % nb);
    mask = (longint'(1) << (8 * nb)) - 1;
    if (mis)          lat = 0;
    else if (!w)      lat = 2;
    else if (nb == 4) lat = 1;
    else              lat = 3;
    if (!mis) begin
      word = longint'(model_mem[idx]);
      if (w) begin
        model_mem[idx] = 32'((word & ~(mask << (8 * off))) |
                             ((longint'(wd) & mask) << (8 * off)));
      end else begin
        val = (word >> (8 * off)) & mask;
        if (sx && nb < 4 && (((val >> (8 * nb - 1)) & 1) == 1)) val = val | ~mask;
        model_rdata = 32'(val);
      end
    end

    @(negedge clock);
    check({tag, "_ready_before"}, 32'(ready), 32'd1);
    we0       = we_count;
    req       = 1'b1;
    wr        = w;
    size      = sz;
    sign_ext  = sx;
    byte_addr = (AW+2)'(addr);
    wdata     = wd;
    @(posedge clock);
    @(negedge clock);
    req       = 1'b0;
    byte_addr = (AW+2)'($urandom);
    wdata     = $urandom;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_misaligned"}, 32'(misaligned), 32'(mis));
    got = rdata;
    check({tag, "_rdata"}, rdata, model_rdata);
    if (w && !mis) begin
      check({tag, "_wr_addr"}, 32'(last_wr_addr), 32'(idx));
      check({tag, "_wr_data"}, last_wr_data, model_mem[idx]);
    end
    check({tag, "_we_cycles"}, 32'(we_count - we0), 32'(w && !mis));
    @(negedge clock);
    check({tag, "_done_1cycle"}, 32'(done), 32'd0);
    check({tag, "_ready_after"}, 32'(ready), 32'd1);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] prev;
    int          acc, dn, we0;

    reset_n = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b00; sign_ext = 1'b0;
    byte_addr = '0; wdata = '0;
    model_rdata = 32'h0;
    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;

    // Reset values.
    repeat (3) @(negedge clock);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_rd_addr", 32'(mem_read_addr), 32'd0);
    check("rst_wr_addr", 32'(mem_write_addr), 32'd0);
    check("rst_mem_data", mem_data, 32'h0);
    reset_n = 1'b1;

    // Fill the test region with known words through the controller.
    for (int i = 0; i < 16; i++) do_req("fill", 1'b1, 2'b10, 1'b0, 4 * i, $urandom, got);

    // Word store then word load.
    do_req("st_word", 1'b1, 2'b10, 1'b0, 'h10, 32'hDEADBEEF, got);
    do_req("ld_word", 1'b0, 2'b10, 1'b0, 'h10, 32'h0, got);
    check("tp_word_rdata", got, 32'hDEADBEEF);

    // Byte store over 0x11223344, then word and byte loads.
    do_req("st_base", 1'b1, 2'b10, 1'b0, 'h10, 32'h11223344, got);
    do_req("st_byte", 1'b1, 2'b00, 1'b0, 'h12, 32'h000000A5, got);
    do_req("ld_merge", 1'b0, 2'b10, 1'b0, 'h10, 32'h0, got);
    check("tp_byte_merge", got, 32'h11A53344);
    do_req("ld_bs", 1'b0, 2'b00, 1'b1, 'h12, 32'h0, got);
    check("tp_byte_signed", got, 32'hFFFFFFA5);
    do_req("ld_bu", 1'b0, 2'b00, 1'b0, 'h12, 32'h0, got);
    check("tp_byte_unsigned", got, 32'h000000A5);

    // Half load at an odd address.
    prev = rdata;
    do_req("ld_odd_half", 1'b0, 2'b01, 1'b0, 'h13, 32'h0, got);
`ifdef MEM_CTRL_ALIGN_CHECK_EN
    check("tp_misaligned_rdata_kept", got, prev);
`else
    check("tp_unchecked_half_lane1", got, 32'h000011A5);
`endif

    // Half store over 0xCAFEBABE.
    do_req("st_base2", 1'b1, 2'b10, 1'b0, 'h14, 32'hCAFEBABE, got);
    do_req("st_half", 1'b1, 2'b01, 1'b0, 'h16, 32'h00008001, got);
    do_req("ld_hs", 1'b0, 2'b01, 1'b1, 'h16, 32'h0, got);
    check("tp_half_signed", got, 32'hFFFF8001);
    do_req("ld_hmerge", 1'b0, 2'b10, 1'b0, 'h14, 32'h0, got);
    check("tp_half_merge", got, 32'h8001BABE);

    // req held high: loads accepted only when ready, one done each.
    @(negedge clock);
    we0 = we_count;
    acc = 0; dn = 0;
    req = 1'b1; wr = 1'b0; size = 2'b10; sign_ext = 1'b0; byte_addr = (AW+2)'('h10);
    for (int i = 0; i < 16; i++) begin
      if (ready && req) acc++;
      if (done) dn++;
      @(negedge clock);
    end
    req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) dn++;
      @(negedge clock);
    end
    model_rdata = model_mem[4];
    check("held_accepts", 32'(acc), 32'd4);
    check("held_dones", 32'(dn), 32'd4);
    check("held_rdata", rdata, model_rdata);
    check("held_no_write", 32'(we_count - we0), 32'd0);

    // Reset during CAP of a byte store: the word must stay untouched.
    do_req("rst_prep", 1'b1, 2'b10, 1'b0, 'h20, 32'h0BADF00D, got);
    @(negedge clock);
    we0 = we_count;
    req = 1'b1; wr = 1'b1; size = 2'b00; sign_ext = 1'b0;
    byte_addr = (AW+2)'('h21); wdata = 32'h00000077;
    @(posedge clock);
    @(negedge clock);
    req = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_rdata", rdata, 32'h0);
    check("abort_mem_data", mem_data, 32'h0);
    check("abort_rd_addr", 32'(mem_read_addr), 32'd0);
    model_rdata = 32'h0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    check("abort_no_write", 32'(we_count - we0), 32'd0);
    do_req("ld_after_abort", 1'b0, 2'b10, 1'b0, 'h20, 32'h0, got);
    check("tp_abort_word_kept", got, 32'h0BADF00D);

    // Randomized accesses inside the modelled region.
    for (int i = 0; i < 40; i++) begin
      do_req("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), $urandom, got);
    end

    // Final readback of every modelled word.
    for (int i = 0; i < 16; i++) do_req("readback", 1'b0, 2'b10, 1'b0, 4 * i, 32'h0, got);

    check("we_pulse_width", 32'(we_long), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
